// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: plays a RAM-stored LED pattern of 4/8/12 steps paced by a tick timebase
module led_pattern_sequencer #(
    parameter int ON_TICKS  = 2,
    parameter int GAP_TICKS = 1
) (
    input  logic       clk_1,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] level,
    input  logic       tick,
    input  logic       abort,
    input  logic [2:0] pat_data,
    output logic [3:0] pat_addr,
    output logic [7:0] led,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, DONE} state_t;
    localparam logic [3:0] ON_LAST  = 4'(ON_TICKS - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);
    state_t state;
    logic [3:0] step, length, tcnt;
    logic fc, last, adv;
    assign last = step == length - 4'd1;
    assign adv  = tick && ((state == SHOW && tcnt == ON_LAST && GAP_TICKS == 0) ||
                           (state == GAP && tcnt == GAP_LAST));
    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            length   <= '0;
            tcnt     <= '0;
            fc       <= 1'b0;
            pat_addr <= '0;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                led   <= '0;
                step  <= '0;
                tcnt  <= '0;
                fc    <= 1'b0;
                busy  <= 1'b0;
            end else if (adv) begin
                tcnt <= '0;
                led  <= '0;
                if (last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    step     <= step + 4'd1;
                    pat_addr <= step + 4'd1;
                    fc       <= 1'b0;
                    state    <= FETCH;
                end
            end else begin
                case (state)
                    IDLE: if (start && level != 2'd0) begin
                        length   <= {level, 2'b00};
                        step     <= '0;
                        pat_addr <= '0;
                        fc       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                    FETCH: begin
                        fc <= ~fc;
                        if (fc) begin
                            led   <= 8'b1 << pat_data;
                            tcnt  <= '0;
                            state <= SHOW;
                        end
                    end
                    SHOW: if (tick) begin
                        if (tcnt == ON_LAST) begin
                            led   <= '0;
                            tcnt  <= '0;
                            state <= GAP;
                        end else tcnt <= tcnt + 4'd1;
                    end
                    GAP: if (tick) tcnt <= tcnt + 4'd1;
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed checks of playback, abort, reset and ignored requests
module tb_led_pattern_sequencer;
    logic clk_1 = 0, reset = 1, start = 0, abort = 0, tick = 0;
    logic [1:0] level = 0;
    logic [2:0] pat_data;
    logic [3:0] pat_addr;
    logic [7:0] led;
    logic busy, done;
    int pass = 0, total = 0;
    int tick_period = 0, tick_cnt = 0;
    logic [2:0] ram [16];
    logic [2:0] pat12 [12] = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd1};
    logic [7:0] exp12 [12] = '{8'h01, 8'h10, 8'h40, 8'h80, 8'h08, 8'h20, 8'h40, 8'h08, 8'h20, 8'h40, 8'h08, 8'h02};
    logic [7:0] led_q [$];
    logic [3:0] addr_q [$];
    int ticks_q [$];
    int done_cnt = 0, busy_cyc = 0, multi_hot = 0, show_ticks = 0;
    logic [7:0] prev_led = 0;

    led_pattern_sequencer dut (
        .clk_1(clk_1), .reset(reset), .start(start), .level(level), .tick(tick), .abort(abort),
        .pat_data(pat_data), .pat_addr(pat_addr), .led(led), .busy(busy), .done(done)
    );

    always #5 clk_1 = ~clk_1;
    always @(posedge clk_1) pat_data <= ram[pat_addr];

    initial forever begin
        @(negedge clk_1);
        tick_cnt++;
        tick = (tick_period > 0) && (tick_cnt % tick_period == 0);
    end

    always @(posedge clk_1) begin
        #1;
        if ($countones(led) > 1) multi_hot++;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (prev_led != 0 && tick) show_ticks++;
        if (prev_led != 0 && led == 0) ticks_q.push_back(show_ticks);
        if (prev_led == 0 && led != 0) begin
            led_q.push_back(led);
            addr_q.push_back(pat_addr);
            show_ticks = 0;
        end
        prev_led = led;
    end

    task clear_mon;
        led_q.delete(); addr_q.delete(); ticks_q.delete();
        done_cnt = 0; busy_cyc = 0;
    endtask

    task load_ram;
        for (int i = 0; i < 16; i++) ram[i] = (i < 12) ? pat12[i] : 3'd0;
    endtask

    task pulse_start(input logic [1:0] lv);
        @(negedge clk_1); level = lv; start = 1;
        @(negedge clk_1); start = 0; level = 0;
    endtask

    task wait_idle(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_1);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task test_reset;
        repeat (2) @(negedge clk_1);
        total++; if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else pass++;
        total++; if (pat_addr !== 4'h0) $display("FAIL reset_addr: got %h want 0", pat_addr); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass++;
        reset = 0;
    endtask

    task test_level1;
        bit ok;
        tick_period = 20; load_ram(); clear_mon();
        pulse_start(2'd1);
        wait_idle(1000, ok);
        total++; if (!ok) $display("FAIL l1_timeout: busy still %b want 0", busy); else pass++;
        total++; if (led_q.size() != 4) $display("FAIL l1_steps: got %0d want 4", led_q.size()); else pass++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= led_q.size() || led_q[i] !== exp12[i]) $display("FAIL l1_led%0d: got %h want %h", i, (i < led_q.size()) ? led_q[i] : 8'hxx, exp12[i]);
            else pass++;
            total++;
            if (i >= ticks_q.size() || ticks_q[i] != 2) $display("FAIL l1_on_ticks%0d: got %0d want 2", i, (i < ticks_q.size()) ? ticks_q[i] : -1);
            else pass++;
        end
        total++; if (done_cnt != 1) $display("FAIL l1_done: got %0d pulses want 1", done_cnt); else pass++;
    endtask

    task test_level0;
        logic [3:0] saved;
        saved = pat_addr; clear_mon();
        pulse_start(2'd0);
        repeat (10) @(negedge clk_1);
        total++; if (busy_cyc != 0) $display("FAIL l0_busy: got %0d busy cycles want 0", busy_cyc); else pass++;
        total++; if (led !== 8'h00) $display("FAIL l0_led: got %h want 00", led); else pass++;
        total++; if (pat_addr !== saved) $display("FAIL l0_addr: got %h want %h", pat_addr, saved); else pass++;
    endtask

    task test_start_while_busy;
        bit ok;
        tick_period = 5; clear_mon();
        pulse_start(2'd1);
        repeat (30) @(negedge clk_1);
        pulse_start(2'd3);
        wait_idle(1000, ok);
        total++; if (!ok) $display("FAIL busy_start_timeout: busy still %b want 0", busy); else pass++;
        total++; if (led_q.size() != 4) $display("FAIL busy_start_steps: got %0d want 4", led_q.size()); else pass++;
        total++; if (done_cnt != 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task test_level3;
        bit ok;
        tick_period = 3; clear_mon();
        pulse_start(2'd3);
        wait_idle(2000, ok);
        total++; if (!ok) $display("FAIL l3_timeout: busy still %b want 0", busy); else pass++;
        total++; if (led_q.size() != 12) $display("FAIL l3_steps: got %0d want 12", led_q.size()); else pass++;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (i >= led_q.size() || led_q[i] !== exp12[i] || addr_q[i] !== 4'(i))
                $display("FAIL l3_step%0d: got led %h addr %h want led %h addr %h", i,
                         (i < led_q.size()) ? led_q[i] : 8'hxx, (i < addr_q.size()) ? addr_q[i] : 4'hx, exp12[i], 4'(i));
            else pass++;
        end
        total++; if (done_cnt != 1) $display("FAIL l3_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task test_tick_every_cycle;
        bit ok;
        tick_period = 1; clear_mon();
        pulse_start(2'd1);
        wait_idle(500, ok);
        total++; if (!ok) $display("FAIL tick1_timeout: busy still %b want 0", busy); else pass++;
        total++; if (busy_cyc != 21) $display("FAIL tick1_busy_cycles: got %0d want 21", busy_cyc); else pass++;
        total++; if (ticks_q.size() != 4 || ticks_q[0] != 2 || ticks_q[3] != 2)
            $display("FAIL tick1_on_ticks: got %0d shows first %0d want 4 shows of 2", ticks_q.size(), (ticks_q.size() > 0) ? ticks_q[0] : -1);
        else pass++;
        total++; if (done_cnt != 1) $display("FAIL tick1_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task test_abort;
        bit ok;
        tick_period = 4; clear_mon();
        pulse_start(2'd1);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_1);
            if (led == 8'h10) begin ok = 1; break; end
        end
        total++; if (!ok) $display("FAIL abort_reach_step: led %h want 10", led); else pass++;
        abort = 1;
        @(posedge clk_1); #1;
        total++; if (led !== 8'h00 || busy !== 1'b0) $display("FAIL abort_next: got led %h busy %b want 00 0", led, busy); else pass++;
        @(negedge clk_1); abort = 0;
        repeat (20) @(negedge clk_1);
        total++; if (done_cnt != 0 || busy !== 1'b0) $display("FAIL abort_no_done: got %0d pulses busy %b want 0 0", done_cnt, busy); else pass++;
        clear_mon();
        pulse_start(2'd1);
        wait_idle(1000, ok);
        total++; if (!ok || led_q.size() != 4 || led_q[0] !== 8'h01 || addr_q[0] !== 4'h0)
            $display("FAIL abort_replay: got %0d steps first led %h addr %h want 4 01 0", led_q.size(),
                     (led_q.size() > 0) ? led_q[0] : 8'hxx, (addr_q.size() > 0) ? addr_q[0] : 4'hx);
        else pass++;
        total++; if (done_cnt != 1) $display("FAIL abort_replay_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task test_reset_mid;
        bit ok;
        tick_period = 4; clear_mon();
        pulse_start(2'd2);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_1);
            if (ticks_q.size() == 2) begin ok = 1; break; end
        end
        total++; if (!ok) $display("FAIL rst_reach_gap: got %0d shows want 2", ticks_q.size()); else pass++;
        reset = 1; #1;
        total++; if (led !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pat_addr !== 4'h0)
            $display("FAIL rst_mid_outputs: got led %h busy %b done %b addr %h want 00 0 0 0", led, busy, done, pat_addr);
        else pass++;
        @(negedge clk_1); reset = 0;
        clear_mon();
        pulse_start(2'd2);
        wait_idle(1000, ok);
        total++; if (!ok) $display("FAIL rst_replay_timeout: busy still %b want 0", busy); else pass++;
        total++; if (led_q.size() != 8) $display("FAIL rst_replay_steps: got %0d want 8", led_q.size()); else pass++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= addr_q.size() || addr_q[i] !== 4'(i) || led_q[i] !== exp12[i])
                $display("FAIL rst_replay_step%0d: got addr %h led %h want %h %h", i,
                         (i < addr_q.size()) ? addr_q[i] : 4'hx, (i < led_q.size()) ? led_q[i] : 8'hxx, 4'(i), exp12[i]);
            else pass++;
        end
        total++; if (done_cnt != 1) $display("FAIL rst_replay_done: got %0d want 1", done_cnt); else pass++;
    endtask

    initial begin
        test_reset();
        test_level1();
        test_level0();
        test_start_while_busy();
        test_level3();
        test_tick_every_cycle();
        test_abort();
        test_reset_mid();
        total++; if (multi_hot != 0) $display("FAIL onehot: got %0d multi-hot cycles want 0", multi_hot); else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
